// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the rate-1/2 convolutional encoder: seed load, MSB-first payload, zero tail, framed output.
// Optional rate-2/3 puncturing qualifier on out_v2 is enabled by defining CONV_PUNCTURE_EN.
module conv_frame_ctrl #(
  parameter int         FRAME_BITS = 8,
  parameter int         TAIL_BITS  = 2,
  parameter logic [2:0] SEED       = 3'b101,
  parameter int         ENC_LAT    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [FRAME_BITS-1:0] i_in_data,
  output logic                  o_enc_load,
  output logic [2:0]            o_enc_seed,
  output logic                  o_enc_data,
  input  logic                  i_enc_v1,
  input  logic                  i_enc_v2,
  output logic                  o_out_valid,
  output logic                  o_out_v1,
  output logic                  o_out_v2,
  output logic                  o_out_v2_vld,
  output logic                  o_out_last,
  output logic                  o_busy
);

  localparam int TOTAL_BITS = FRAME_BITS + TAIL_BITS;
  localparam int CW         = $clog2(TOTAL_BITS + 1);
  localparam logic [CW-1:0] C_FRAME = CW'(FRAME_BITS);
  localparam logic [CW-1:0] C_TOTAL = CW'(TOTAL_BITS);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DATA,
    S_TAIL,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_word;
  logic [CW-1:0]         r_cnt;
  logic                  r_bit_vld;
  logic                  r_bit_last;
  logic                  r_in_ready;
  logic                  r_enc_load;
  logic [2:0]            r_enc_seed;
  logic                  r_enc_data;
  logic                  r_busy;

  logic                  w_out_valid;
  logic                  w_out_last;

  // r_cnt holds the number of bits already driven onto enc_data this frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_cnt      <= '0;
      r_bit_vld  <= 1'b0;
      r_bit_last <= 1'b0;
      r_in_ready <= 1'b0;
      r_enc_load <= 1'b0;
      r_enc_seed <= 3'b000;
      r_enc_data <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_word     <= i_in_data;
            r_state    <= S_LOAD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_enc_load <= 1'b1;
            r_enc_seed <= SEED;
            r_enc_data <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end

        S_LOAD: begin
          r_enc_load <= 1'b0;
          r_enc_seed <= 3'b000;
          r_enc_data <= r_word[FRAME_BITS-1];
          r_word     <= r_word << 1;
          r_cnt      <= C_ONE;
          r_bit_vld  <= 1'b1;
          r_bit_last <= (C_TOTAL == C_ONE);
          r_state    <= S_DATA;
        end

        S_DATA, S_TAIL: begin
          if (r_cnt == C_TOTAL) begin
            r_bit_vld  <= 1'b0;
            r_bit_last <= 1'b0;
            r_enc_data <= 1'b0;
            r_cnt      <= '0;
            if (ENC_LAT > 0) begin
              r_state <= S_DRAIN;
            end else begin
              r_state    <= S_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
          end else begin
            r_cnt      <= r_cnt + C_ONE;
            r_bit_last <= ((r_cnt + C_ONE) == C_TOTAL);
            if (r_cnt < C_FRAME) begin
              r_enc_data <= r_word[FRAME_BITS-1];
              r_word     <= r_word << 1;
              r_state    <= S_DATA;
            end else begin
              r_enc_data <= 1'b0;
              r_state    <= S_TAIL;
            end
          end
        end

        S_DRAIN: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_bit_vld  <= 1'b0;
          r_bit_last <= 1'b0;
          r_enc_load <= 1'b0;
          r_enc_seed <= 3'b000;
          r_enc_data <= 1'b0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // The bit-phase strobes are re-timed to line up with the encoder's registered outputs.
  generate
    if (ENC_LAT == 0) begin : g_lat0
      assign w_out_valid = r_bit_vld;
      assign w_out_last  = r_bit_last;
    end else begin : g_lat1
      logic r_vld_d;
      logic r_last_d;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vld_d  <= 1'b0;
          r_last_d <= 1'b0;
        end else begin
          r_vld_d  <= r_bit_vld;
          r_last_d <= r_bit_last;
        end
      end
      assign w_out_valid = r_vld_d;
      assign w_out_last  = r_last_d;
    end
  endgenerate

`ifdef CONV_PUNCTURE_EN
  logic [CW-1:0] r_pair_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pair_idx <= '0;
    end else if (w_out_valid) begin
      r_pair_idx <= w_out_last ? '0 : (r_pair_idx + C_ONE);
    end
  end

  assign o_out_v2_vld = w_out_valid & ~r_pair_idx[0];
`else
  assign o_out_v2_vld = w_out_valid;
`endif

  assign o_in_ready  = r_in_ready;
  assign o_enc_load  = r_enc_load;
  assign o_enc_seed  = r_enc_seed;
  assign o_enc_data  = r_enc_data;
  assign o_busy      = r_busy;
  assign o_out_valid = w_out_valid;
  assign o_out_v1    = w_out_valid & i_enc_v1;
  assign o_out_v2    = w_out_valid & i_enc_v2;
  assign o_out_last  = w_out_last;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl with a behavioural K=3 encoder (g1=111, g2=101, 1-cycle latency).
// Expected pairs go into a scoreboard queue at each accepted handshake; a negedge monitor pops and compares.
module tb_conv_frame_ctrl;

  localparam int NPAIR = 10;

  logic       clk = 1'b0;
  logic       rstN;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       encLoad;
  logic [2:0] encSeed;
  logic       encData;
  logic       encV1 = 1'b0;
  logic       encV2 = 1'b0;
  logic       outValid;
  logic       outV1;
  logic       outV2;
  logic       outV2Vld;
  logic       outLast;
  logic       busy;

  typedef struct packed {
    logic v1;
    logic v2;
    logic v2vld;
    logic last;
  } pair_t;

  pair_t expQ[$];
  pair_t monExp;
  logic [2:0] encSr = 3'b000;
  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  conv_frame_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_in_data    (inData),
    .o_enc_load   (encLoad),
    .o_enc_seed   (encSeed),
    .o_enc_data   (encData),
    .i_enc_v1     (encV1),
    .i_enc_v2     (encV2),
    .o_out_valid  (outValid),
    .o_out_v1     (outV1),
    .o_out_v2     (outV2),
    .o_out_v2_vld (outV2Vld),
    .o_out_last   (outLast),
    .o_busy       (busy)
  );

  // Encoder stand-in: shift register {s1,s0}, new bit d; v1 = s1^s0^d, v2 = s1^d.
  always @(posedge clk) begin
    if (encLoad) begin
      encSr <= encSeed;
      encV1 <= 1'b0;
      encV2 <= 1'b0;
    end else begin
      encSr <= {encSr[1:0], encData};
      encV1 <= encSr[1] ^ encSr[0] ^ encData;
      encV2 <= encSr[1] ^ encData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExpected(input logic [2:0] seed, input logic [7:0] d);
    logic [2:0] sr;
    logic       b;
    pair_t      e;
    sr = seed;
    for (int i = 0; i < NPAIR; i++) begin
      b = (i < 8) ? d[7-i] : 1'b0;
      e.v1 = sr[1] ^ sr[0] ^ b;
      e.v2 = sr[1] ^ b;
`ifdef CONV_PUNCTURE_EN
      e.v2vld = ((i % 2) == 0);
`else
      e.v2vld = 1'b1;
`endif
      e.last = (i == NPAIR - 1);
      sr = {sr[1:0], b};
      expQ.push_back(e);
    end
  endtask

  // Called at a negedge; returns right after the accepting posedge (edge 0 of the frame).
  task automatic applyStimulus(input logic [7:0] d);
    int waitCnt;
    waitCnt = 0;
    inValid = 1'b1;
    inData  = d;
    while (!inReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!inReady)
      checkOutput("handshake_timeout", {31'd0, inReady}, 32'd1);
    else
      pushExpected(3'b101, d);
    @(posedge clk);
  endtask

  task automatic checkFrame(input logic [7:0] d, input bit hold, input logic [7:0] nextData);
    int idx;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("load_cycle", {encLoad, encSeed, inReady, busy}, {1'b1, 3'b101, 1'b0, 1'b1});
        if (hold) inData = 8'h5A;
        else inValid = 1'b0;
      end else if (k <= 11) begin
        idx = 9 - k;
        checkOutput("enc_data", {encLoad, encSeed, encData},
                    {1'b0, 3'b000, (k <= 9) ? d[idx] : 1'b0});
      end else if (k == 12) begin
        checkOutput("drain_busy", {inReady, busy}, 2'b01);
        if (hold) inData = nextData;
      end else begin
        checkOutput("ready_back", {inReady, busy}, 2'b10);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      if (outValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pair", {31'd0, outValid}, 32'd0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("pair", {outV1, outV2, outV2Vld, outLast}, monExp);
        end
      end else begin
        checkOutput("idle_quiet", {outV1, outV2, outV2Vld, outLast}, 4'b0000);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", nFails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN    = 1'b1;
    inValid = 1'b0;
    inData  = 8'h00;
    #1 rstN = 1'b0;
    #9;
    checkOutput("reset_outputs",
                {inReady, encLoad, encSeed, encData, outValid, outV1, outV2, outV2Vld, outLast, busy}, 12'd0);
    #12 rstN = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", {inReady, busy}, 2'b10);

    $display("[TB] single frame 8'hA5");
    applyStimulus(8'hA5);
    checkFrame(8'hA5, 1'b0, 8'h00);

    $display("[TB] back-to-back 8'hFF then 8'h00 with in_valid held");
    applyStimulus(8'hFF);
    checkFrame(8'hFF, 1'b1, 8'h00);
    applyStimulus(8'h00);
    checkFrame(8'h00, 1'b0, 8'h00);

    $display("[TB] frame 8'h3C");
    applyStimulus(8'h3C);
    checkFrame(8'h3C, 1'b0, 8'h00);

    $display("[TB] reset in cycle 6 of frame 8'hC3");
    applyStimulus(8'hC3);
    @(negedge clk);
    inValid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abort_outputs",
                {inReady, encLoad, encSeed, encData, outValid, outV1, outV2, outV2Vld, outLast, busy}, 12'd0);
    expQ.delete();
    @(negedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_abort", {inReady, busy}, 2'b10);
    applyStimulus(8'hA5);
    checkFrame(8'hA5, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
